// File: rtl/rtc_pkg.sv
// Shared types and constant tables for the RTC multiplexed-bus sequencer.
// The scan and init tables are case-based lookups so they map onto plain muxes.
package rtc_pkg;

  typedef enum logic [1:0] {
    MODE_RST  = 2'b00,
    MODE_INIT = 2'b01,
    MODE_READ = 2'b10,
    MODE_EDIT = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_SET = 3'd1,
    ST_ADDR_STB = 3'd2,
    ST_DATA_SET = 3'd3,
    ST_DATA_STB = 3'd4,
    ST_HOLD     = 3'd5
  } state_t;

  localparam logic [3:0] SCAN_LAST = 4'd8;
  localparam logic [1:0] INIT_LAST = 2'd2;

  // Time-of-day registers first, then the timer registers.
  function automatic logic [7:0] scan_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h41;
      4'd7:    a = 8'h42;
      4'd8:    a = 8'h43;
      default: a = 8'h21;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] init_addr(input logic [1:0] idx);
    logic [7:0] a;
    case (idx)
      2'd0:    a = 8'h02;
      2'd1:    a = 8'h00;
      2'd2:    a = 8'h10;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] init_data(input logic [1:0] idx);
    logic [7:0] d;
    case (idx)
      2'd0:    d = 8'h10;
      2'd1:    d = 8'h00;
      2'd2:    d = 8'hD2;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Per-phase down-counter: loaded with PHASE_CYC-1 on phase entry,
// phase_done flags the terminal count (last cycle of the phase).
module rtc_phase_timer #(
  parameter int PHASE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic phase_done
);

  localparam logic [3:0] TC_LOAD = 4'(PHASE_CYC - 1);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= TC_LOAD;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign phase_done = (count == 4'd0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences init writes, periodic register scans and host edits onto an
// RTC multiplexed address/data bus; every transaction runs five timed phases.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | bus released; picks the next transaction from mode
// ADDR_SET  | address driven on AD, cs_n low
// ADDR_STB  | address held, wr_n low to latch it in the RTC
// DATA_SET  | data phase setup (write drives AD, read releases it)
// DATA_STB  | wr_n (write) or rd_n (read) low; read data sampled at end
// HOLD      | bus released, strobes high; read result published
module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       rd_valid,
  output logic [3:0] rd_idx,
  output logic [7:0] rd_data,
  output logic       init_done,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic       ad_oe,
  output logic [7:0] ad_out,
  input  logic [7:0] ad_in
);

  mode_t      mode_e;
  state_t     state_q, state_d;
  logic       phase_done;
  logic       timer_load;
  logic       start_read, start_init, start_edit;

  logic       is_read_q, is_init_q;
  logic [7:0] addr_q, data_q;
  logic [3:0] scan_idx_q;
  logic [1:0] init_idx_q;
  logic       init_complete_q;
  logic       rd_valid_q, init_done_q;
  logic [3:0] rd_idx_q;
  logic [7:0] rd_data_q;
  logic       read_finish, txn_finish;

  assign mode_e = mode_t'(mode);

  rtc_phase_timer #(
    .PHASE_CYC (PHASE_CYC)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .phase_done (phase_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_read = 1'b0;
    start_init = 1'b0;
    start_edit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // reset gating keeps wr_ack quiet during the cycles reset is held
        if (reset) begin
          case (mode_e)
            MODE_INIT: start_init = !init_complete_q;
            MODE_READ: start_read = 1'b1;
            MODE_EDIT: start_edit = wr_req;
            default:   ;
          endcase
        end
        if (start_init || start_read || start_edit) state_d = ST_ADDR_SET;
      end
      ST_ADDR_SET: if (phase_done) state_d = ST_ADDR_STB;
      ST_ADDR_STB: if (phase_done) state_d = ST_DATA_SET;
      ST_DATA_SET: if (phase_done) state_d = ST_DATA_STB;
      ST_DATA_STB: if (phase_done) state_d = ST_HOLD;
      ST_HOLD:     if (phase_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign timer_load  = (state_d != state_q) && (state_d != ST_IDLE);
  assign read_finish = (state_q == ST_DATA_STB) && phase_done && is_read_q;
  assign txn_finish  = (state_q == ST_HOLD) && phase_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      is_read_q       <= 1'b0;
      is_init_q       <= 1'b0;
      addr_q          <= 8'h00;
      data_q          <= 8'h00;
      scan_idx_q      <= 4'd0;
      init_idx_q      <= 2'd0;
      init_complete_q <= 1'b0;
      rd_valid_q      <= 1'b0;
      init_done_q     <= 1'b0;
      rd_idx_q        <= 4'd0;
      rd_data_q       <= 8'h00;
    end else begin
      rd_valid_q  <= 1'b0;
      init_done_q <= 1'b0;

      if (start_read) begin
        is_read_q <= 1'b1;
        is_init_q <= 1'b0;
        addr_q    <= scan_addr(scan_idx_q);
        data_q    <= 8'h00;
      end
      if (start_init) begin
        is_read_q <= 1'b0;
        is_init_q <= 1'b1;
        addr_q    <= init_addr(init_idx_q);
        data_q    <= init_data(init_idx_q);
      end
      if (start_edit) begin
        is_read_q <= 1'b0;
        is_init_q <= 1'b0;
        addr_q    <= wr_addr;
        data_q    <= wr_data;
      end

      if (read_finish) begin
        rd_valid_q <= 1'b1;
        rd_idx_q   <= scan_idx_q;
        rd_data_q  <= ad_in;
        scan_idx_q <= (scan_idx_q == SCAN_LAST) ? 4'd0 : scan_idx_q + 4'd1;
      end

      if (txn_finish && is_init_q) begin
        if (init_idx_q == INIT_LAST) begin
          init_idx_q      <= 2'd0;
          init_complete_q <= 1'b1;
          init_done_q     <= 1'b1;
        end else begin
          init_idx_q <= init_idx_q + 2'd1;
        end
      end

      // Mode effects on the sequence pointers only apply between transactions.
      if (state_q == ST_IDLE) begin
        if (mode_e == MODE_RST) begin
          scan_idx_q <= 4'd0;
          init_idx_q <= 2'd0;
        end
        if (mode_e != MODE_INIT) init_complete_q <= 1'b0;
      end
    end
  end

  always_comb begin
    cs_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    a_d    = 1'b0;
    ad_oe  = 1'b0;
    ad_out = 8'h00;
    case (state_q)
      ST_ADDR_SET, ST_ADDR_STB: begin
        cs_n   = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
        wr_n   = (state_q != ST_ADDR_STB);
      end
      ST_DATA_SET, ST_DATA_STB: begin
        cs_n = 1'b0;
        a_d  = 1'b1;
        if (is_read_q) begin
          rd_n = (state_q != ST_DATA_STB);
        end else begin
          ad_oe  = 1'b1;
          ad_out = data_q;
          wr_n   = (state_q != ST_DATA_STB);
        end
      end
      default: ;
    endcase
  end

  assign wr_ack    = start_edit;
  assign rd_valid  = rd_valid_q;
  assign rd_idx    = rd_idx_q;
  assign rd_data   = rd_data_q;
  assign init_done = init_done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: transaction-offset reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_rtc_bus_sequencer;

  localparam int P = 4;
  localparam int K_READ = 0;
  localparam int K_INIT = 1;
  localparam int K_EDIT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic       wr_req;
  logic [7:0] wr_addr, wr_data, ad_in;
  logic       wr_ack, rd_valid, init_done, busy;
  logic [3:0] rd_idx;
  logic [7:0] rd_data, ad_out;
  logic       cs_n, rd_n, wr_n, a_d, ad_oe;

  rtc_bus_sequencer #(.PHASE_CYC(P)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .rd_valid  (rd_valid),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .init_done (init_done),
    .busy      (busy),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .a_d       (a_d),
    .ad_oe     (ad_oe),
    .ad_out    (ad_out),
    .ad_in     (ad_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference tables
  logic [7:0] scan_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] init_a   [3] = '{8'h02, 8'h00, 8'h10};
  logic [7:0] init_d   [3] = '{8'h10, 8'h00, 8'hD2};

  // Model: a transaction is an offset m_k counting cycles since its start.
  bit         m_active;
  int         m_k, m_kind, m_scan, m_init;
  bit         m_init_complete;
  logic [7:0] m_addr, m_data;
  bit         e_rd_valid, e_init_done;
  int         e_rd_idx;
  logic [7:0] e_rd_data;

  always @(posedge clk) begin
    if (!reset) begin
      m_active = 0; m_k = 0; m_scan = 0; m_init = 0; m_init_complete = 0;
      e_rd_valid = 0; e_init_done = 0; e_rd_idx = 0; e_rd_data = 8'h00;
    end else begin
      e_rd_valid = 0;
      e_init_done = 0;
      if (m_active) begin
        m_k++;
        if (m_kind == K_READ && m_k == 4 * P) begin
          e_rd_valid = 1;
          e_rd_idx = m_scan;
          e_rd_data = ad_in;
          m_scan = (m_scan + 1) % 9;
        end
        if (m_k == 5 * P) begin
          m_active = 0;
          if (m_kind == K_INIT) begin
            if (m_init == 2) begin
              m_init = 0;
              m_init_complete = 1;
              e_init_done = 1;
            end else m_init++;
          end
        end
      end else begin
        if (mode == 2'b01 && !m_init_complete) begin
          m_active = 1; m_k = 0; m_kind = K_INIT; m_addr = init_a[m_init]; m_data = init_d[m_init];
        end else if (mode == 2'b10) begin
          m_active = 1; m_k = 0; m_kind = K_READ; m_addr = scan_tab[m_scan]; m_data = 8'h00;
        end else if (mode == 2'b11 && wr_req) begin
          m_active = 1; m_k = 0; m_kind = K_EDIT; m_addr = wr_addr; m_data = wr_data;
        end
        if (mode == 2'b00) begin
          m_scan = 0;
          m_init = 0;
        end
        if (mode != 2'b01) m_init_complete = 0;
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic e_cs, e_rd, e_wr, e_ad, e_oe, e_ack;
      logic [7:0] e_out;
      int ph;
      e_cs = 1; e_rd = 1; e_wr = 1; e_ad = 0; e_oe = 0; e_out = 8'h00;
      if (m_active) begin
        ph = m_k / P;
        if (ph < 2) begin
          e_cs = 0; e_oe = 1; e_out = m_addr; e_wr = (ph != 1);
        end else if (ph < 4) begin
          e_cs = 0; e_ad = 1;
          if (m_kind == K_READ) e_rd = (ph != 3);
          else begin
            e_oe = 1; e_out = m_data; e_wr = (ph != 3);
          end
        end
      end
      e_ack = reset && !m_active && (mode == 2'b11) && wr_req;
      check("busy", busy, m_active);
      check("cs_n", cs_n, e_cs);
      check("rd_n", rd_n, e_rd);
      check("wr_n", wr_n, e_wr);
      check("a_d", a_d, e_ad);
      check("ad_oe", ad_oe, e_oe);
      check("ad_out", ad_out, e_out);
      check("wr_ack", wr_ack, e_ack);
      check("rd_valid", rd_valid, e_rd_valid);
      check("rd_idx", rd_idx, e_rd_idx);
      check("rd_data", rd_data, e_rd_data);
      check("init_done", init_done, e_init_done);
    end
  end

  // Event monitor feeding the directed literal checks.
  logic [7:0] q_addr[$];
  logic [7:0] q_data[$];
  int         q_idx[$];
  int         rd_cnt, ack_cnt, init_cnt, wrn_low;
  bit         prev_wr_n = 1;
  bit         last_ack = 0;

  always @(negedge clk) begin
    if (prev_wr_n && wr_n === 1'b0) begin
      if (a_d) q_data.push_back(ad_out);
      else     q_addr.push_back(ad_out);
    end
    prev_wr_n = (wr_n !== 1'b0);
    if (wr_n === 1'b0) wrn_low++;
    if (rd_valid === 1'b1) begin
      rd_cnt++;
      q_idx.push_back(int'(rd_idx));
    end
    if (wr_ack === 1'b1) ack_cnt++;
    if (init_done === 1'b1) init_cnt++;
    last_ack = (wr_ack === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q_addr.delete(); q_data.delete(); q_idx.delete();
    rd_cnt = 0; ack_cnt = 0; init_cnt = 0; wrn_low = 0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 60) begin
      tick(1);
      g++;
    end
    check("wait_idle_timeout", g < 60, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_scan_addr [10];
    int cyc, cs_low, g;
    bit got;
    exp_scan_addr = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43, 8'h21};

    reset = 0; mode = 2'b00; wr_req = 0; wr_addr = 8'h00; wr_data = 8'h00; ad_in = 8'h00;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_cs_n", cs_n, 1);
    check("reset_rd_idx", rd_idx, 0);
    check("reset_rd_data", rd_data, 0);
    tick(2);

    // First scan read: mode set while reset still held for 4 more edges.
    clear_mon();
    mode = 2'b10; ad_in = 8'h59;
    tick(4);
    reset = 1;
    cyc = 4; cs_low = 0; got = 0;
    while (!got && cyc < 60) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (rd_valid === 1'b1) got = 1;
      else if (cs_n === 1'b0) cs_low++;
    end
    check("first_rd_latency", cyc, 21);
    check("first_rd_idx", rd_idx, 0);
    check("first_rd_data", rd_data, 8'h59);
    check("cs_low_cycles", cs_low, 16);

    // Ten consecutive scan reads.
    g = 0;
    while (rd_cnt < 10 && g < 300) begin
      tick(1);
      g++;
    end
    check("scan_count", rd_cnt >= 10, 1);
    for (int i = 0; i < 10; i++) begin
      check("scan_idx_seq", (i < q_idx.size()) ? q_idx[i] : 99, i % 9);
      check("scan_addr_seq", (i < q_addr.size()) ? q_addr[i] : 8'hFF, exp_scan_addr[i]);
    end
    mode = 2'b00;
    wait_idle();
    tick(2);

    // Init table.
    clear_mon();
    mode = 2'b01;
    tick(120);
    check("init_writes", q_addr.size(), 3);
    check("init_a0", q_addr.size() > 0 ? q_addr[0] : 8'hFF, 8'h02);
    check("init_d0", q_data.size() > 0 ? q_data[0] : 8'hFF, 8'h10);
    check("init_a1", q_addr.size() > 1 ? q_addr[1] : 8'hFF, 8'h00);
    check("init_d1", q_data.size() > 1 ? q_data[1] : 8'hFF, 8'h00);
    check("init_a2", q_addr.size() > 2 ? q_addr[2] : 8'hFF, 8'h10);
    check("init_d2", q_data.size() > 2 ? q_data[2] : 8'hFF, 8'hD2);
    check("init_done_pulses", init_cnt, 1);
    mode = 2'b00;
    tick(3);

    // Host edit.
    clear_mon();
    mode = 2'b11; wr_addr = 8'h22; wr_data = 8'h30; wr_req = 1;
    got = 0; g = 0;
    while (!got && g < 10) begin
      @(negedge clk);
      if (wr_ack === 1'b1) got = 1;
      g++;
    end
    check("edit_ack_seen", got, 1);
    tick(1);
    wr_req = 0; wr_addr = 8'hEE; wr_data = 8'hEE;
    tick(30);
    check("edit_ack_pulses", ack_cnt, 1);
    check("edit_addr", q_addr.size() > 0 ? q_addr[0] : 8'hFF, 8'h22);
    check("edit_data", q_data.size() > 0 ? q_data[0] : 8'hFF, 8'h30);
    check("edit_wr_n_low", wrn_low, 8);

    // Mode 10 -> 11 in the third DATA_STB cycle.
    clear_mon();
    mode = 2'b10; ad_in = 8'h3C;
    g = 0;
    while (!(m_active && m_k == 14) && g < 40) begin
      tick(1);
      g++;
    end
    check("reach_data_stb3", g < 40, 1);
    mode = 2'b11;
    tick(60);
    check("switch_rd_count", rd_cnt, 1);
    check("switch_rd_data", rd_data, 8'h3C);
    check("switch_no_more_reads", q_addr.size(), 1);

    // Reset during DATA_STB of a read.
    clear_mon();
    mode = 2'b10;
    g = 0;
    while (!(m_active && m_k == 13) && g < 40) begin
      tick(1);
      g++;
    end
    check("reach_data_stb", g < 40, 1);
    reset = 0;
    tick(1);
    @(negedge clk);
    check("abort_cs_n", cs_n, 1);
    check("abort_rd_n", rd_n, 1);
    check("abort_ad_oe", ad_oe, 0);
    check("abort_busy", busy, 0);
    tick(1);
    reset = 1; mode = 2'b00;
    tick(30);
    check("abort_no_rd_valid", rd_cnt, 0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      tick(1);
      ad_in = 8'($urandom);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if (last_ack) wr_req = 0;
      else if (!wr_req && $urandom_range(0, 7) == 0) begin
        wr_req = 1;
        wr_addr = 8'($urandom);
        wr_data = 8'($urandom);
      end
      reset = ($urandom_range(0, 599) != 0);
    end
    reset = 1;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
